// File: rtl/png_pxl_feeder.sv
// Row sequencer that reads RGBA pixels from a frame SRAM and streams them to
// png_top one row at a time, pacing rows on png_top's per-row completion.
module png_pxl_feeder #(
   parameter int SIZE_W_WD   = 10,
   parameter int SIZE_H_WD   = 10,
   parameter int DATA_PXL_WD = 32,
   parameter int ADDR_WD     = 20,
   parameter int GAP_CYC     = 10
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [SIZE_W_WD-1:0]   cfg_w_i,
   input  logic [SIZE_H_WD-1:0]   cfg_h_i,
   input  logic                   start_i,
   output logic                   done_o,
   output logic                   rd_en_o,
   output logic [ADDR_WD-1:0]     rd_addr_o,
   input  logic [DATA_PXL_WD-1:0] rd_dat_i,
   output logic                   png_start_o,
   output logic                   png_val_o,
   output logic [DATA_PXL_WD-1:0] png_dat_o,
   input  logic                   png_row_done_i,
   input  logic                   png_done_i
);

   typedef enum logic [2:0] {
      IDLE, ROW_START, STRM, ROW_WAIT, GAP, FIN_WAIT, DONE
   } state_t;

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

   state_t               state;
   logic [SIZE_W_WD-1:0] w_q;
   logic [SIZE_H_WD-1:0] h_q;
   logic [SIZE_W_WD-1:0] col;
   logic [SIZE_H_WD-1:0] row;
   logic [ADDR_WD-1:0]   addr;
   logic [7:0]           gap_cnt;
   logic                 rd_en_d1;
   logic                 row_flag;
   logic                 done_flag;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         w_q         <= '0;
         h_q         <= '0;
         col         <= '0;
         row         <= '0;
         addr        <= '0;
         gap_cnt     <= '0;
         rd_en_d1    <= 1'b0;
         row_flag    <= 1'b0;
         done_flag   <= 1'b0;
         done_o      <= 1'b0;
         rd_en_o     <= 1'b0;
         rd_addr_o   <= '0;
         png_start_o <= 1'b0;
         png_val_o   <= 1'b0;
         png_dat_o   <= '0;
      end else begin
         png_start_o <= 1'b0;
         done_o      <= 1'b0;
         rd_en_o     <= 1'b0;

         // Two-stage pipe: SRAM latency plus the output register.
         rd_en_d1  <= rd_en_o;
         png_val_o <= rd_en_d1;
         if (rd_en_d1) png_dat_o <= rd_dat_i;

         // Completion pulses may arrive early; latch them until consumed.
         if (state != IDLE && png_row_done_i) row_flag  <= 1'b1;
         if (state != IDLE && png_done_i)     done_flag <= 1'b1;

         case (state)
            IDLE: begin
               if (start_i) begin
                  w_q  <= cfg_w_i;
                  h_q  <= cfg_h_i;
                  row  <= '0;
                  addr <= '0;
                  if (cfg_w_i == '0 || cfg_h_i == '0) begin
                     state <= DONE;
                  end else begin
                     state       <= ROW_START;
                     png_start_o <= 1'b1;
                  end
               end
            end
            ROW_START: begin
               col       <= '0;
               state     <= STRM;
               rd_en_o   <= 1'b1;
               rd_addr_o <= addr;
               addr      <= addr + 1'b1;
            end
            STRM: begin
               // col indexes the read currently presented on rd_addr_o.
               if (col == w_q - 1'b1) begin
                  state <= ROW_WAIT;
               end else begin
                  col       <= col + 1'b1;
                  rd_en_o   <= 1'b1;
                  rd_addr_o <= addr;
                  addr      <= addr + 1'b1;
               end
            end
            ROW_WAIT: begin
               // rd_en_d1 low means the row's last pixel is already on png_val_o.
               if (row_flag && !rd_en_d1) begin
                  row_flag <= 1'b0;
                  if (row == h_q - 1'b1) begin
                     state <= FIN_WAIT;
                  end else begin
                     row     <= row + 1'b1;
                     gap_cnt <= '0;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state       <= ROW_START;
                  png_start_o <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            FIN_WAIT: begin
               if (done_flag) state <= DONE;
            end
            DONE: begin
               done_o    <= 1'b1;
               row_flag  <= 1'b0;
               done_flag <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_png_pxl_feeder.sv
// Directed bench for png_pxl_feeder: SRAM model, event monitor, and timing
// checks against hand-derived cycle numbers.
module tb_png_pxl_feeder;

   localparam int GAP   = 3;
   localparam int S_RD  = 0;
   localparam int S_VAL = 1;
   localparam int S_DN  = 2;
   localparam int S_ST  = 3;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [9:0]  cfg_w = '0;
   logic [9:0]  cfg_h = '0;
   logic        start = 1'b0;
   logic        done;
   logic        rd_en;
   logic [19:0] rd_addr;
   logic [31:0] rd_dat = '0;
   logic        png_start;
   logic        png_val;
   logic [31:0] png_dat;
   logic        row_done = 1'b0;
   logic        frm_done = 1'b0;

   png_pxl_feeder #(
      .SIZE_W_WD(10), .SIZE_H_WD(10), .DATA_PXL_WD(32), .ADDR_WD(20), .GAP_CYC(GAP)
   ) dut (
      .clk(clk), .rstn(rstn), .cfg_w_i(cfg_w), .cfg_h_i(cfg_h), .start_i(start),
      .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_dat_i(rd_dat),
      .png_start_o(png_start), .png_val_o(png_val), .png_dat_o(png_dat),
      .png_row_done_i(row_done), .png_done_i(frm_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] pix(input logic [19:0] a);
      return {8'hA0 ^ a[7:0], a[7:0], ~a[7:0], 8'h5C};
   endfunction

   // SRAM with one cycle read latency
   always @(posedge clk) rd_dat <= rd_en ? pix(rd_addr) : 32'hDEAD_BEEF;

   int          n_rd, n_val, n_done, n_start, done_cyc, run, lastv;
   logic [19:0] addr_q[$];
   int          start_q[$];
   int          vrise_q[$];
   int          vend_q[$];
   int          run_q[$];
   logic        vprev = 1'b0;

   always @(negedge clk) begin
      if (rd_en) begin
         addr_q.push_back(rd_addr);
         n_rd++;
      end
      if (png_start) begin
         start_q.push_back(cyc);
         n_start++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (png_val) begin
         check("pix_dat", png_dat, pix(20'(n_val)));
         n_val++;
         if (!vprev) begin
            run = 0;
            vrise_q.push_back(cyc);
         end
         run++;
         lastv = cyc;
      end else if (vprev) begin
         run_q.push_back(run);
         vend_q.push_back(lastv);
      end
      vprev = png_val;
   end

   task automatic clr();
      n_rd = 0; n_val = 0; n_done = 0; n_start = 0; done_cyc = -1;
      addr_q.delete(); start_q.delete(); vrise_q.delete();
      vend_q.delete(); run_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int cnt(input int sel);
      case (sel)
         S_RD:    return n_rd;
         S_VAL:   return n_val;
         S_DN:    return n_done;
         default: return n_start;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int n);
      int b = 0;
      while (cnt(sel) < n && b < 300) begin
         tick(1);
         b++;
      end
      check(tag, 32'(cnt(sel) >= n), 32'd1);
   endtask

   task automatic go(input int w, input int h, output int s);
      cfg_w = 10'(w);
      cfg_h = 10'(h);
      start = 1'b1;
      s = cyc;
      tick(1);
      start = 1'b0;
   endtask

   task automatic serve_row(input int nval, input int dly, output int p);
      wait_for("row_vals", S_VAL, nval);
      tick(dly);
      row_done = 1'b1;
      p = cyc;
      tick(1);
      row_done = 1'b0;
   endtask

   task automatic pulse_done();
      frm_done = 1'b1;
      tick(1);
      frm_done = 1'b0;
   endtask

   initial begin
      int s, p0, p1, mark;
      clr();
      tick(2);
      check("rst_done", 32'(done), 0);
      check("rst_rd_en", 32'(rd_en), 0);
      check("rst_addr", 32'(rd_addr), 0);
      check("rst_start", 32'(png_start), 0);
      check("rst_val", 32'(png_val), 0);
      check("rst_dat", png_dat, 0);
      rstn = 1'b1;
      tick(2);

      // 4x2 frame
      clr();
      go(4, 2, s);
      serve_row(4, 4, p0);
      serve_row(8, 4, p1);
      tick(1);
      pulse_done();
      wait_for("t1_done_seen", S_DN, 1);
      tick(4);
      check("t1_n_rd", 32'(n_rd), 8);
      for (int i = 0; i < 8; i++)
         if (i < addr_q.size()) check("t1_addr", 32'(addr_q[i]), 32'(i));
      check("t1_n_val", 32'(n_val), 8);
      check("t1_n_start", 32'(n_start), 2);
      check("t1_start0", 32'(start_q.size() > 0 ? start_q[0] : -1), 32'(s + 1));
      check("t1_start1", 32'(start_q.size() > 1 ? start_q[1] : -1), 32'(p0 + GAP + 2));
      check("t1_vrise0", 32'(vrise_q.size() > 0 ? vrise_q[0] : -1), 32'(s + 4));
      check("t1_vrise1", 32'(vrise_q.size() > 1 ? vrise_q[1] : -1), 32'(p0 + GAP + 5));
      check("t1_run0", 32'(run_q.size() > 0 ? run_q[0] : -1), 4);
      check("t1_run1", 32'(run_q.size() > 1 ? run_q[1] : -1), 4);
      check("t1_done_cyc", 32'(done_cyc), 32'(p1 + 5));
      check("t1_n_done", 32'(n_done), 1);

      // zero width
      clr();
      go(0, 5, s);
      wait_for("t2_done_seen", S_DN, 1);
      tick(3);
      check("t2_done_cyc", 32'(done_cyc), 32'(s + 2));
      check("t2_n_start", 32'(n_start), 0);
      check("t2_n_rd", 32'(n_rd), 0);
      check("t2_n_done", 32'(n_done), 1);

      // 3x3 with ignored restart during STRM
      clr();
      go(3, 3, s);
      wait_for("t3_in_strm", S_RD, 1);
      go(7, 7, mark);
      serve_row(3, 2, p0);
      serve_row(6, 2, p0);
      serve_row(9, 2, p0);
      pulse_done();
      wait_for("t3_done_seen", S_DN, 1);
      tick(3);
      check("t3_n_rd", 32'(n_rd), 9);
      for (int i = 0; i < 9; i++)
         if (i < addr_q.size()) check("t3_addr", 32'(addr_q[i]), 32'(i));
      check("t3_n_start", 32'(n_start), 3);
      check("t3_n_done", 32'(n_done), 1);

      // early row-done during STRM of an 8-wide row
      clr();
      go(8, 2, s);
      wait_for("t4_in_strm", S_RD, 3);
      row_done = 1'b1;
      tick(1);
      row_done = 1'b0;
      serve_row(16, 3, p1);
      pulse_done();
      wait_for("t4_done_seen", S_DN, 1);
      tick(3);
      check("t4_run0", 32'(run_q.size() > 0 ? run_q[0] : -1), 8);
      check("t4_run1", 32'(run_q.size() > 1 ? run_q[1] : -1), 8);
      check("t4_start1", 32'(start_q.size() > 1 ? start_q[1] : -1),
            32'((vend_q.size() > 0 ? vend_q[0] : -100) + GAP + 1));
      check("t4_n_rd", 32'(n_rd), 16);
      check("t4_n_done", 32'(n_done), 1);

      // reset during row 1 of 4x4, then a fresh frame
      clr();
      go(4, 4, s);
      serve_row(4, 2, p0);
      wait_for("t5_row1_strm", S_RD, 6);
      rstn = 1'b0;
      #1;
      check("t5_rst_rd_en", 32'(rd_en), 0);
      check("t5_rst_addr", 32'(rd_addr), 0);
      check("t5_rst_start", 32'(png_start), 0);
      check("t5_rst_val", 32'(png_val), 0);
      check("t5_rst_dat", png_dat, 0);
      check("t5_rst_done", 32'(done), 0);
      tick(1);
      rstn = 1'b1;
      mark = n_rd;
      tick(12);
      check("t5_no_reads", 32'(n_rd), 32'(mark));
      check("t5_no_done", 32'(n_done), 0);
      clr();
      go(2, 1, s);
      serve_row(2, 1, p0);
      pulse_done();
      wait_for("t5_done_seen", S_DN, 1);
      check("t5_addr0", 32'(addr_q.size() > 0 ? addr_q[0] : 20'hFFFFF), 0);
      check("t5_addr1", 32'(addr_q.size() > 1 ? addr_q[1] : 20'hFFFFF), 1);

      // 1x1 with simultaneous row-done and frame-done
      clr();
      go(1, 1, s);
      wait_for("t6_val", S_VAL, 1);
      tick(1);
      row_done = 1'b1;
      frm_done = 1'b1;
      p0 = cyc;
      tick(1);
      row_done = 1'b0;
      frm_done = 1'b0;
      wait_for("t6_done_seen", S_DN, 1);
      tick(5);
      check("t6_done_cyc", 32'(done_cyc), 32'(p0 + 4));
      check("t6_n_done", 32'(n_done), 1);
      check("t6_n_rd", 32'(n_rd), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
